// File: rtl/reaction_display_pkg.sv
// Shared constants for the reaction-time display: segment font, FSM encodings and BCD helpers.
package reaction_display_pkg;

  localparam int unsigned BCD_W = 16;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  // Active-low {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  // Double-dabble correction applied before each shift.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    s = SEG_BLANK;
    if (nib <= 4'd9) s = SEG_DIGIT[nib];
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary-to-BCD converter, one double-dabble step per clock.
module bin2bcd_seq
  import reaction_display_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [BCD_W-1:0]  value_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [BCD_W-1:0]  bcd_o
);

  logic [1:0]       state_q, state_d;
  logic [15:0]      bin_q, bin_d;
  logic [BCD_W-1:0] acc_q, acc_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BCD_W-1:0] adj;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    adj     = bcd_adjust(acc_q);
    case (state_q)
      StIdle: begin
        if (start_i) begin
          bin_d   = value_i;
          acc_d   = '0;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        {acc_d, bin_d} = {adj, bin_q} << 1;
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = StDone;
      end
      StDone: begin
        bcd_d   = acc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      bin_q   <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/reaction_time_display.sv
// 4-digit multiplexed 7-segment display of the reaction-timer result.
// Define LEADING_ZERO_BLANK_EN to blank leading zeros in result mode.
module reaction_time_display
  import reaction_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned SAT_VALUE   = 9999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        show_result,
  input  logic        waiting,
  input  logic [15:0] time_ms,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        busy,
  output logic        conv_done,
  output logic        overflow
);

  localparam int unsigned CntW   = $clog2(REFRESH_DIV);
  localparam logic [15:0] SatVal = 16'(SAT_VALUE);

  logic             show_q;
  logic             start, capture, over_sat;
  logic [15:0]      sat_val;
  logic [BCD_W-1:0] bcd;
  logic             overflow_q, overflow_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic [3:0]       nib;
  logic             lz_blank;

  assign start    = show_result & ~show_q;
  // The converter only accepts a start while idle, which is exactly when busy is low.
  assign capture  = start & ~busy;
  assign over_sat = time_ms > SatVal;
  assign sat_val  = over_sat ? SatVal : time_ms;

  bin2bcd_seq u_conv (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .start_i (start),
    .value_i (sat_val),
    .busy_o  (busy),
    .done_o  (conv_done),
    .bcd_o   (bcd)
  );

  always_comb begin
    overflow_d = capture ? over_sat : overflow_q;
    cnt_d      = cnt_q + CntW'(1);
    idx_d      = idx_q;
    if (cnt_q == CntW'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  always_comb begin
    nib = 4'(bcd >> {idx_q, 2'b00});
`ifdef LEADING_ZERO_BLANK_EN
    lz_blank = (idx_q != 2'd0) && ((bcd >> {idx_q, 2'b00}) == '0);
`else
    lz_blank = 1'b0;
`endif
    an_d  = 4'hF;
    seg_d = SEG_BLANK;
    if (show_result) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = lz_blank ? SEG_BLANK : seg_decode(nib);
    end else if (waiting) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = SEG_DASH;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      show_q     <= 1'b0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      seg_q      <= SEG_BLANK;
      an_q       <= 4'hF;
    end else begin
      show_q     <= show_result;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_reaction_time_display.sv
// Randomized bench for reaction_time_display with a cycle-level reference model and a
// capture-to-conv_done scoreboard.
module tb_reaction_time_display;

  localparam int RDIV = 4;
  localparam int SAT  = 9999;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        show_result = 1'b0;
  logic        waiting = 1'b0;
  logic [15:0] time_ms = 16'd0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        busy, conv_done, overflow;

  always #5 clk = ~clk;

  reaction_time_display #(
    .REFRESH_DIV (RDIV),
    .SAT_VALUE   (SAT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .show_result (show_result),
    .waiting     (waiting),
    .time_ms     (time_ms),
    .seg         (seg),
    .an          (an),
    .busy        (busy),
    .conv_done   (conv_done),
    .overflow    (overflow)
  );

  int passed = 0;
  int total  = 0;

  logic [6:0] font [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00,
                             7'h10};

  typedef struct {
    int cap_edge;
    bit ovf;
  } cap_t;
  cap_t sb_q[$];

  // Reference model state: edges since reset release, pending conversion, displayed value.
  int         e_n = 0;
  bit         m_show_q = 1'b0;
  bit         m_pend = 1'b0;
  int         m_done_edge = 0;
  int         m_val = 0;
  int         m_disp = 0;
  bit         m_ovf = 1'b0;
  logic [6:0] exp_seg = 7'h7F;
  logic [3:0] exp_an = 4'hF;
  bit         exp_busy = 1'b0;
  bit         exp_done = 1'b0;

  function automatic logic [6:0] exp_digit(input int val, input int pos);
    int p;
    p = 1;
    for (int i = 0; i < pos; i++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (pos > 0 && val / p == 0) return 7'h7F;
`endif
    return font[(val / p) % 10];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
  endtask

  initial begin : model
    int n;
    int idx;
    bit done_now;
    bit cap;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        e_n      = 0;
        m_show_q = 1'b0;
        m_pend   = 1'b0;
        m_disp   = 0;
        m_ovf    = 1'b0;
        exp_seg  = 7'h7F;
        exp_an   = 4'hF;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        sb_q.delete();
      end else begin
        n   = e_n + 1;
        e_n = n;
        idx = ((n - 1) / RDIV) % 4;
        if (show_result) begin
          exp_an  = ~(4'b0001 << idx);
          exp_seg = exp_digit(m_disp, idx);
        end else if (waiting) begin
          exp_an  = ~(4'b0001 << idx);
          exp_seg = 7'h3F;
        end else begin
          exp_an  = 4'hF;
          exp_seg = 7'h7F;
        end
        done_now = m_pend && (n == m_done_edge);
        cap      = show_result && !m_show_q && !m_pend;
        if (done_now) begin
          m_disp = m_val;
          m_pend = 1'b0;
        end
        if (cap) begin
          m_pend      = 1'b1;
          m_done_edge = n + 17;
          m_val       = (int'(time_ms) > SAT) ? SAT : int'(time_ms);
          m_ovf       = int'(time_ms) > SAT;
          sb_q.push_back(cap_t'{cap_edge: n, ovf: int'(time_ms) > SAT});
        end
        exp_done = done_now;
        exp_busy = m_pend;
        m_show_q = show_result;
      end
    end
  end

  initial begin : monitor
    cap_t c;
    forever begin
      @(negedge clk);
      check("seg", 16'(seg), 16'(exp_seg));
      check("an", 16'(an), 16'(exp_an));
      check("busy", 16'(busy), 16'(exp_busy));
      check("conv_done", 16'(conv_done), 16'(exp_done));
      check("overflow", 16'(overflow), 16'(m_ovf));
      if (conv_done === 1'b1) begin
        check("sb_pop", 16'(sb_q.size() > 0), 16'd1);
        if (sb_q.size() > 0) begin
          c = sb_q.pop_front();
          check("sb_latency", 16'(e_n - c.cap_edge), 16'd17);
          check("sb_ovf", 16'(overflow), 16'(c.ovf));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_capture(input logic [15:0] v, input int hold);
    time_ms     = v;
    show_result = 1'b1;
    tick(1);
    time_ms = 16'($urandom);
    tick(hold - 1);
    show_result = 1'b0;
    tick(3);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog at %0t", $time);
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    logic [15:0] dir [8] = '{16'd1234, 16'd12000, 16'd500, 16'd42, 16'd0, 16'd9999,
                             16'd10000, 16'd65535};
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    tick(4);
    reset_n = 1'b1;
    tick(8);

    waiting = 1'b1;
    tick(40);

    foreach (dir[i]) do_capture(dir[i], 40);

    // Second rise while busy must be ignored.
    time_ms     = 16'd777;
    show_result = 1'b1;
    tick(3);
    show_result = 1'b0;
    tick(2);
    show_result = 1'b1;
    tick(40);
    show_result = 1'b0;
    tick(3);

    // Reset in the middle of a conversion discards it.
    time_ms     = 16'd4321;
    show_result = 1'b1;
    tick(9);
    reset_n     = 1'b0;
    show_result = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(30);

    for (int it = 0; it < 40; it++) begin
      waiting = 1'($urandom);
      case ($urandom % 4)
        0:       time_ms = 16'($urandom % 10000);
        1:       time_ms = 16'($urandom % 100);
        2:       time_ms = 16'($urandom);
        default: time_ms = 16'(9990 + $urandom % 20);
      endcase
      show_result = 1'b1;
      tick($urandom_range(3, 45));
      show_result = 1'b0;
      tick($urandom_range(1, 10));
    end

    tick(25);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
